// File: rtl/maxterm_sweep_pkg.sv
// Shared types and helpers for the maxterm sweep controller.
package maxterm_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } sweep_state_e;

    localparam int               IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

    // Index width that never collapses to zero bits for a single unit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxterm_sweep_ctrl_if.sv
// Stimulus/response bus between the sweep controller and the bank of function units.
interface maxterm_sweep_ctrl_if #(
    parameter int N_FUNC = 5
);
    import maxterm_sweep_pkg::*;

    localparam int FW = clog2_min1(N_FUNC);

    // The units are purely combinational: {x,y,z} is held by the controller and
    // s_in/ctrl_in are only trusted after the settle interval has elapsed.
    logic              x;
    logic              y;
    logic              z;
    logic [FW-1:0]     func_idx;
    logic [N_FUNC-1:0] s_in;
    logic [N_FUNC-1:0] ctrl_in;

    modport master (output x, y, z, func_idx, input s_in, ctrl_in);
    modport slave  (input x, y, z, func_idx, output s_in, ctrl_in);

endinterface

// File: rtl/maxterm_sweep_ctrl_sweep_point_counter.sv
// Nested index/function counter walking every (func, idx) point of a sweep.
module sweep_point_counter
    import maxterm_sweep_pkg::*;
#(
    parameter int N_FUNC = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          advance,
    output logic [IDX_W-1:0]              idx,
    output logic [clog2_min1(N_FUNC)-1:0] func,
    output logic                          last
);

    localparam int            FW        = clog2_min1(N_FUNC);
    localparam logic [FW-1:0] LAST_FUNC = FW'(N_FUNC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            func <= '0;
        end else if (clear) begin
            idx  <= '0;
            func <= '0;
        end else if (advance) begin
            if (idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end else if (func != LAST_FUNC) begin
                idx  <= '0;
                func <= func + 1'b1;
            end
        end
    end

    assign last = (idx == LAST_IDX) && (func == LAST_FUNC);

endmodule

// File: rtl/maxterm_sweep_ctrl.sv
// Exhaustive reduced-vs-canonical equivalence sweep over N_FUNC 3-input units.
// Optional per-sample trace outputs are enabled with SWEEP_TRACE_EN.
module maxterm_sweep_ctrl
    import maxterm_sweep_pkg::*;
#(
    parameter int N_FUNC = 5,
    parameter int SETTLE = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    maxterm_sweep_ctrl_if.master                unit,
    output logic                                busy,
    output logic                                done,
    output logic [N_FUNC-1:0]                   pass_mask,
    output logic [$clog2(8*N_FUNC+1)-1:0]       err_count,
    output logic                                first_err_valid,
    output logic [clog2_min1(N_FUNC)-1:0]       first_err_func,
    output logic [IDX_W-1:0]                    first_err_idx,
`ifdef SWEEP_TRACE_EN
    output logic                                trace_valid,
    output logic [clog2_min1(N_FUNC)-1:0]       trace_func,
    output logic [IDX_W-1:0]                    trace_idx,
    output logic                                trace_s,
    output logic                                trace_ctrl,
`endif
    output sweep_state_e                        state_dbg
);

    localparam int FW = clog2_min1(N_FUNC);

    sweep_state_e     state, state_nxt;
    logic [3:0]       settle_cnt;
    logic [IDX_W-1:0] idx;
    logic [FW-1:0]    func;
    logic             last_point;
    logic             sweep_clear;
    logic             point_advance;
    logic             sample_fire;
    logic             mismatch;

    sweep_point_counter #(.N_FUNC(N_FUNC)) u_points (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (sweep_clear),
        .advance (point_advance),
        .idx     (idx),
        .func    (func),
        .last    (last_point)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Abort beats every busy-state transition, including a pending sample.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_APPLY;
            ST_APPLY: begin
                if (abort)            state_nxt = ST_IDLE;
                else if (SETTLE == 0) state_nxt = ST_SAMPLE;
                else                  state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort)                state_nxt = ST_IDLE;
                else if (settle_cnt <= 1) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)           state_nxt = ST_IDLE;
                else if (last_point) state_nxt = ST_FINISH;
                else                 state_nxt = ST_APPLY;
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 settle_cnt <= '0;
        else if (state == ST_APPLY) settle_cnt <= 4'(SETTLE);
        else if (state == ST_WAIT)  settle_cnt <= settle_cnt - 1'b1;
    end

    assign sweep_clear   = (state == ST_IDLE) && start;
    assign sample_fire   = (state == ST_SAMPLE) && !abort;
    assign point_advance = sample_fire && !last_point;
    assign mismatch      = unit.s_in[func] != unit.ctrl_in[func];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_mask       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_func  <= '0;
            first_err_idx   <= '0;
        end else if (sweep_clear) begin
            pass_mask       <= '1;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_func  <= '0;
            first_err_idx   <= '0;
        end else if (sample_fire && mismatch) begin
            pass_mask[func] <= 1'b0;
            err_count       <= err_count + 1'b1;
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_func  <= func;
                first_err_idx   <= idx;
            end
        end
    end

`ifdef SWEEP_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_func  <= '0;
            trace_idx   <= '0;
            trace_s     <= 1'b0;
            trace_ctrl  <= 1'b0;
        end else begin
            trace_valid <= sample_fire;
            if (sample_fire) begin
                trace_func <= func;
                trace_idx  <= idx;
                trace_s    <= unit.s_in[func];
                trace_ctrl <= unit.ctrl_in[func];
            end
        end
    end
`endif

    assign busy          = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_SAMPLE);
    assign done          = (state == ST_FINISH);
    assign unit.x        = busy & idx[2];
    assign unit.y        = busy & idx[1];
    assign unit.z        = busy & idx[0];
    assign unit.func_idx = busy ? func : '0;
    assign state_dbg     = state;

endmodule

// File: tb/tb_maxterm_sweep_ctrl.sv
// Directed bench for maxterm_sweep_ctrl: a 5-unit SETTLE=1 instance and a 1-unit SETTLE=0 instance.
module tb_maxterm_sweep_ctrl;
    import maxterm_sweep_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    maxterm_sweep_ctrl_if #(.N_FUNC(5)) bus0 ();
    maxterm_sweep_ctrl_if #(.N_FUNC(1)) bus1 ();

    logic         busy0, done0, fev0;
    logic [4:0]   pass0;
    logic [5:0]   err0;
    logic [2:0]   fef0, fei0;
    sweep_state_e state0;
    logic         busy1, done1, fev1;
    logic [0:0]   pass1, fef1;
    logic [3:0]   err1;
    logic [2:0]   fei1;
    sweep_state_e state1;
`ifdef SWEEP_TRACE_EN
    logic       tv0, ts0, tc0, tv1, ts1, tc1;
    logic [2:0] tf0, ti0, ti1;
    logic [0:0] tf1;
`endif

    maxterm_sweep_ctrl #(.N_FUNC(5), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .unit(bus0),
        .busy(busy0), .done(done0), .pass_mask(pass0), .err_count(err0),
        .first_err_valid(fev0), .first_err_func(fef0), .first_err_idx(fei0),
`ifdef SWEEP_TRACE_EN
        .trace_valid(tv0), .trace_func(tf0), .trace_idx(ti0), .trace_s(ts0), .trace_ctrl(tc0),
`endif
        .state_dbg(state0)
    );

    maxterm_sweep_ctrl #(.N_FUNC(1), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .unit(bus1),
        .busy(busy1), .done(done1), .pass_mask(pass1), .err_count(err1),
        .first_err_valid(fev1), .first_err_func(fef1), .first_err_idx(fei1),
`ifdef SWEEP_TRACE_EN
        .trace_valid(tv1), .trace_func(tf1), .trace_idx(ti1), .trace_s(ts1), .trace_ctrl(tc1),
`endif
        .state_dbg(state1)
    );

    // Canonical forms as maxterm bitmaps; reduced forms written out as sum/product terms.
    localparam logic [7:0] MT [5] = '{8'hC1, 8'hA2, 8'hAA, 8'h33, 8'h6A};
    logic [4:0] force1 = '0;
    logic [4:0] inv    = '0;
    logic [2:0] xyz0, xyz1;
    logic [4:0] red0;
    logic       x0, y0, z0;

    assign xyz0 = {bus0.x, bus0.y, bus0.z};
    assign xyz1 = {bus1.x, bus1.y, bus1.z};
    assign x0 = bus0.x;
    assign y0 = bus0.y;
    assign z0 = bus0.z;
    assign red0[0] = (x0 | y0 | z0) & (~x0 | ~y0);
    assign red0[1] = (y0 | ~z0) & (~x0 | ~z0);
    assign red0[2] = ~z0;
    assign red0[3] = y0;
    assign red0[4] = (y0 | ~z0) & (x0 | ~z0) & (~x0 | ~y0 | z0);

    always_comb begin
        logic [7:0] m;
        for (int f = 0; f < 5; f++) begin
            m = MT[f];
            bus0.ctrl_in[f] = ~m[xyz0];
            bus0.s_in[f]    = force1[f] ? 1'b1 : (red0[f] ^ inv[f]);
        end
    end

    always_comb begin
        logic [7:0] m;
        m = MT[0];
        bus1.ctrl_in[0] = ~m[xyz1];
        bus1.s_in[0]    = (bus1.x | bus1.y | bus1.z) & (~bus1.x | ~bus1.y);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller raises start just after an edge; cycle 1 is the first cycle after it is sampled.
    task automatic run0(input int budget, input int restart_at, output int done_cyc);
        done_cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start = 1'b0;
                abort = 1'b0;
            end
            if (restart_at != 0 && i == restart_at)     start = 1'b1;
            if (restart_at != 0 && i == restart_at + 1) start = 1'b0;
            if (done0) begin
                done_cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int  dc;
        logic seen;

        // Reset state
        #3;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_fev", fev0, 0);
        chk("rst_xyz", xyz0, 0);
        chk("rst_state", state0, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: all units correct
        @(posedge clk); #1;
        start = 1'b1;
        run0(200, 0, dc);
        chk("s1_done_cycle", dc, 121);
        chk("s1_pass", pass0, 5'b11111);
        chk("s1_err", err0, 0);
        chk("s1_fev", fev0, 0);
        cyc(1);
        chk("s1_done_pulse", done0, 0);
        chk("s1_busy", busy0, 0);
        chk("s1_xyz_idle", xyz0, 0);

        // 2: unit 2 reduced output stuck at 1
        force1 = 5'b00100;
        start = 1'b1;
        run0(200, 0, dc);
        chk("s2_done_cycle", dc, 121);
        chk("s2_pass", pass0, 5'b11011);
        chk("s2_err", err0, 4);
        chk("s2_fev", fev0, 1);
        chk("s2_fef", fef0, 2);
        chk("s2_fei", fei0, 1);
        force1 = '0;

        // 3: unit 1 inverted, abort during SAMPLE of (1,3)
        inv = 5'b00010;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(35);
        chk("s3_at_sample", state0, ST_SAMPLE);
        chk("s3_func", bus0.func_idx, 1);
        chk("s3_xyz", xyz0, 3);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("s3_state", state0, ST_IDLE);
        chk("s3_busy", busy0, 0);
        chk("s3_err", err0, 3);
        chk("s3_pass", pass0, 5'b11101);
        chk("s3_fef", fef0, 1);
        chk("s3_fei", fei0, 0);
        chk("s3_xyz_idle", xyz0, 0);
        seen = done0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            seen = seen | done0;
        end
        chk("s3_no_done", seen, 0);
        inv = '0;

        // 4: start re-pulsed mid-sweep is ignored
        start = 1'b1;
        run0(200, 50, dc);
        chk("s4_done_cycle", dc, 121);
        chk("s4_pass", pass0, 5'b11111);
        chk("s4_err", err0, 0);
        chk("s4_fev", fev0, 0);

        // 5: reset mid-WAIT, then restart with start and abort together
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(19);
        chk("s5_at_wait", state0, ST_WAIT);
        chk("s5_pass_pre", pass0, 5'b11111);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_busy", busy0, 0);
        chk("s5_rst_pass", pass0, 0);
        chk("s5_rst_state", state0, ST_IDLE);
        chk("s5_rst_xyz", xyz0, 0);
        chk("s5_rst_func", bus0.func_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        run0(200, 0, dc);
        chk("s5_done_cycle", dc, 121);
        chk("s5_pass", pass0, 5'b11111);
        chk("s5_err", err0, 0);

        // 6: single unit, no settle
        cyc(1);
        start1 = 1'b1;
        dc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start1 = 1'b0;
            if (i <= 16) chk($sformatf("s6_xyz_c%0d", i), xyz1, 32'((i - 1) / 2));
            if (done1 && dc == 0) dc = i;
        end
        chk("s6_done_cycle", dc, 17);
        chk("s6_pass", pass1, 1);
        chk("s6_err", err1, 0);
        chk("s6_fev", fev1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
